l2_mem_responder: RTL and testbench

Memory-side responder for the 128-bit block interface that the L2 I-cache and L2 D-cache drive as initiators (`mem_read`/`mem_write`/`mem_addr`/`mem_wdata` in, `mem_rdata`/`mem_ready` out). It holds a block-addressed storage array and services one block read or block write at a time with a fixed, parameterised latency. It signals completion with a single-cycle `mem_ready` pulse and flags protocol violations by the initiator. It sits below each L2 instance, as a synthesizable main-memory model and as the far end of the L2 miss/write-back path.

---
 rtl/l2_mem_responder.sv | 143 ++++++++++++++
 tb/tb_l2_mem_responder.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/l2_mem_responder.sv
// l2_mem_responder
//
// Memory-side responder for the 128-bit block interface driven by the L2
// I-cache / D-cache. It holds a block-addressed storage array and services
// one block read or block write at a time with a fixed latency, then signals
// completion with a single-cycle mem_ready pulse.
//
// Handshake: the initiator raises exactly one of mem_read / mem_write with
// mem_addr / mem_wdata and holds all of them stable until it samples
// mem_ready=1 on the edge ending the RESP cycle. The responder works only
// from the values latched at acceptance; any drop or change of the request
// while BUSY/RESP, or both request lines high while IDLE, sets the sticky
// mem_err flag (cleared only by reset).
//
// Parameters:
//   LATENCY   cycles from first request visibility to the mem_ready cycle (2..255)
//   DEPTHW    storage index width; array holds 2**DEPTHW blocks of 128 bits
//
// Ports:
//   clk         clock, all state updates on its rising edge
//   proc_reset  asynchronous active-high reset
//   mem_read    block read request
//   mem_write   block write request
//   mem_addr    block address; only mem_addr[DEPTHW-1:0] indexes storage
//   mem_wdata   write block data
//   mem_rdata   read block data (registered, holds between reads)
//   mem_ready   one-cycle completion pulse (registered)
//   mem_err     sticky protocol-error flag (registered)
//   dbg_state   current FSM state: 0 IDLE, 1 BUSY, 2 RESP

module l2_mem_responder #(
    parameter int LATENCY = 4,
    parameter int DEPTHW  = 6
) (
    input  logic         clk,
    input  logic         proc_reset,
    input  logic         mem_read,
    input  logic         mem_write,
    input  logic [27:0]  mem_addr,
    input  logic [127:0] mem_wdata,
    output logic [127:0] mem_rdata,
    output logic         mem_ready,
    output logic         mem_err,
    output logic [1:0]   dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_RESP = 2'd2
    } state_t;

    localparam int DEPTH = 2 ** DEPTHW;

    // The accept edge starts the first BUSY cycle and the commit edge ends
    // the last, so BUSY lasts LATENCY-1 cycles: count down from LATENCY-2.
    localparam logic [7:0] CNT_LOAD = 8'(LATENCY - 2);

    state_t              state;
    logic [7:0]          cnt;
    logic                op_wr_q;
    logic [27:0]         addr_q;
    logic [127:0]        wdata_q;
    logic [127:0]        mem_array [DEPTH];
    logic [DEPTHW-1:0]   idx;
    logic                req_changed;

    assign idx       = addr_q[DEPTHW-1:0];
    assign dbg_state = state;

    // Compares the live request against the latched one. The full 28-bit
    // address is compared so a change in the aliased upper bits is still
    // seen as a protocol violation. Write data only matters on writes.
    always_comb begin
        req_changed = 1'b0;
        if ((mem_write != op_wr_q) || (mem_read != !op_wr_q)) begin
            req_changed = 1'b1;
        end
        if (mem_addr != addr_q) begin
            req_changed = 1'b1;
        end
        if (op_wr_q && (mem_wdata != wdata_q)) begin
            req_changed = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge proc_reset) begin
        if (proc_reset) begin
            state     <= S_IDLE;
            cnt       <= 8'd0;
            op_wr_q   <= 1'b0;
            addr_q    <= 28'd0;
            wdata_q   <= 128'd0;
            mem_rdata <= 128'd0;
            mem_ready <= 1'b0;
            mem_err   <= 1'b0;
            mem_array <= '{default: '0};
        end else begin
            mem_ready <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (mem_read ^ mem_write) begin
                        op_wr_q <= mem_write;
                        addr_q  <= mem_addr;
                        wdata_q <= mem_wdata;
                        cnt     <= CNT_LOAD;
                        state   <= S_BUSY;
                    end else if (mem_read && mem_write) begin
                        mem_err <= 1'b1;
                    end
                end
                S_BUSY: begin
                    if (req_changed) begin
                        mem_err <= 1'b1;
                    end
                    if (cnt == 8'd0) begin
                        // Commit/read on the same edge that enters RESP so
                        // mem_rdata is valid alongside mem_ready.
                        state     <= S_RESP;
                        mem_ready <= 1'b1;
                        if (op_wr_q) begin
                            mem_array[idx] <= wdata_q;
                        end else begin
                            mem_rdata <= mem_array[idx];
                        end
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                S_RESP: begin
                    if (req_changed) begin
                        mem_err <= 1'b1;
                    end
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_l2_mem_responder.sv
// tb_l2_mem_responder
//
// Directed bench for l2_mem_responder (LATENCY=4, DEPTHW=6). A table of
// back-to-back block transactions with hand-computed results is replayed in
// a loop; the reset, illegal-op and mid-transaction-change cases are written
// out by hand. Inputs are driven 1 ns after the rising edge and outputs are
// sampled at the same point.

module tb_l2_mem_responder;

    localparam int LATENCY = 4;
    localparam int DEPTHW  = 6;
    localparam int MAX_WAIT = 20;

    localparam logic [127:0] PAT_A = 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D;
    localparam logic [127:0] PAT_B = 128'h0BADC0DE_11112222_33334444_55556666;
    localparam logic [127:0] PAT_C = 128'hA5A5A5A5_5A5A5A5A_F0F0F0F0_0F0F0F0F;

    // clock / reset
    logic         clk;
    logic         proc_reset;
    logic         mem_read;
    logic         mem_write;
    logic [27:0]  mem_addr;
    logic [127:0] mem_wdata;
    logic [127:0] mem_rdata;
    logic         mem_ready;
    logic         mem_err;
    logic [1:0]   dbg_state;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    l2_mem_responder #(
        .LATENCY (LATENCY),
        .DEPTHW  (DEPTHW)
    ) dut (
        .clk        (clk),
        .proc_reset (proc_reset),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ready  (mem_ready),
        .mem_err    (mem_err),
        .dbg_state  (dbg_state)
    );

    // scoreboard counters
    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int last_ready_cyc = -1;

    typedef struct {
        logic         wr;
        logic [27:0]  addr;
        logic [127:0] wdata;
        logic [127:0] exp_rdata;
    } vec_t;

    vec_t vecs [9];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Drives one request, waits (bounded) for mem_ready, checks latency,
    // read data and error flag, then drops the request after the RESP cycle.
    task automatic do_txn(input logic wr, input logic [27:0] addr, input logic [127:0] wd,
                          input logic chk_rd, input logic [127:0] exp_rd,
                          input logic exp_err, input string tag);
        int lat;
        lat = 0;
        mem_read  = !wr;
        mem_write = wr;
        mem_addr  = addr;
        mem_wdata = wd;
        for (int i = 1; i <= MAX_WAIT && lat == 0; i++) begin
            cycle();
            if (mem_ready) lat = i;
        end
        check({tag, "_latency"}, 128'(lat), 128'(LATENCY));
        if (lat != 0) last_ready_cyc = cyc;
        if (chk_rd) check({tag, "_rdata"}, mem_rdata, exp_rd);
        check({tag, "_err"}, 128'(mem_err), 128'(exp_err));
        cycle();
        check({tag, "_single_pulse"}, 128'(mem_ready), 128'd0);
        mem_read  = 1'b0;
        mem_write = 1'b0;
    endtask

    initial begin
        int prev_ready;
        int lat;

        // block contents after each entry: 5<-A, 3<-B, 5(alias 0x45)<-1, A<-C
        vecs[0] = '{1'b1, 28'h0000005, PAT_A,   128'd0};
        vecs[1] = '{1'b0, 28'h0000005, 128'd0,  PAT_A};
        vecs[2] = '{1'b1, 28'h0000003, PAT_B,   128'd0};
        vecs[3] = '{1'b1, 28'h0000045, 128'h1,  128'd0};
        vecs[4] = '{1'b0, 28'h0000005, 128'd0,  128'h1};
        vecs[5] = '{1'b1, 28'h000000A, PAT_C,   128'd0};
        vecs[6] = '{1'b0, 28'h0000003, 128'd0,  PAT_B};
        vecs[7] = '{1'b0, 28'h000000A, 128'd0,  PAT_C};
        vecs[8] = '{1'b0, 28'h000003F, 128'd0,  128'd0};

        proc_reset = 1'b1;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_addr   = 28'd0;
        mem_wdata  = 128'd0;
        cycle();
        cycle();
        check("reset_ready", 128'(mem_ready), 128'd0);
        check("reset_rdata", mem_rdata, 128'd0);
        check("reset_err",   128'(mem_err), 128'd0);
        check("reset_state", 128'(dbg_state), 128'd0);
        proc_reset = 1'b0;
        cycle();

        // Table: every request issued the cycle after the previous RESP, so
        // consecutive mem_ready pulses must be LATENCY+1 cycles apart.
        for (int v = 0; v < 9; v++) begin
            prev_ready = last_ready_cyc;
            do_txn(vecs[v].wr, vecs[v].addr, vecs[v].wdata, !vecs[v].wr,
                   vecs[v].exp_rdata, 1'b0, $sformatf("vec%0d", v));
            if (v > 0)
                check($sformatf("vec%0d_b2b_gap", v), 128'(last_ready_cyc - prev_ready),
                      128'(LATENCY + 1));
        end

        // Illegal op: both request lines high for 10 cycles.
        mem_read  = 1'b1;
        mem_write = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cycle();
            check($sformatf("illegal_ready_%0d", i), 128'(mem_ready), 128'd0);
            check($sformatf("illegal_err_%0d", i), 128'(mem_err), 128'd1);
            check($sformatf("illegal_state_%0d", i), 128'(dbg_state), 128'd0);
        end
        mem_read  = 1'b0;
        mem_write = 1'b0;
        cycle();
        cycle();
        cycle();
        check("illegal_err_sticky", 128'(mem_err), 128'd1);

        // Reset mid-transaction: read first so mem_rdata is non-zero.
        do_txn(1'b0, 28'h0000005, 128'd0, 1'b1, 128'h1, 1'b1, "pre_rst_read");
        mem_write = 1'b1;
        mem_addr  = 28'h0000005;
        mem_wdata = PAT_C;
        cycle();
        cycle();
        check("pre_rst_busy", 128'(dbg_state), 128'd1);
        #2;
        proc_reset = 1'b1;
        #1;
        check("midrst_ready", 128'(mem_ready), 128'd0);
        check("midrst_rdata", mem_rdata, 128'd0);
        check("midrst_err",   128'(mem_err), 128'd0);
        check("midrst_state", 128'(dbg_state), 128'd0);
        mem_write = 1'b0;
        cycle();
        proc_reset = 1'b0;
        lat = 0;
        for (int i = 0; i < 8; i++) begin
            cycle();
            if (mem_ready) lat++;
        end
        check("midrst_no_pulse", 128'(lat), 128'd0);
        do_txn(1'b0, 28'h0000005, 128'd0, 1'b1, 128'd0, 1'b0, "post_rst_read");

        // Mid-transaction address change on a write.
        mem_write = 1'b1;
        mem_addr  = 28'h0000007;
        mem_wdata = 128'hAA;
        cycle();
        mem_addr  = 28'h0000008;
        lat = 0;
        for (int i = 2; i <= MAX_WAIT && lat == 0; i++) begin
            cycle();
            if (mem_ready) lat = i;
        end
        check("chg_latency", 128'(lat), 128'(LATENCY));
        check("chg_err", 128'(mem_err), 128'd1);
        cycle();
        check("chg_single_pulse", 128'(mem_ready), 128'd0);
        mem_write = 1'b0;
        do_txn(1'b0, 28'h0000007, 128'd0, 1'b1, 128'hAA, 1'b1, "chg_read7");
        do_txn(1'b0, 28'h0000008, 128'd0, 1'b1, 128'd0,  1'b1, "chg_read8");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        errors++;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog");
    end

endmodule
